pc_next_unit: RTL and testbench
===============================

// Module: pc_next_unit
// PURPOSE
//   Parametrised next-PC generator and PC register for the pipelined MIPS core.
//   Arbitrates sequential, branch, jump, jr, eret and exception redirects by fixed priority.
//   Holds a redirect that arrives while fetch is stalled, then applies it once the stall ends.
//   Checks redirect target alignment and raises an address-error exception on misalignment.
//   Sits between the hazard/CP0 units and the IF-stage instruction-memory address.
// PARAMETERS
//   XLEN      32            address width; all PCs and targets are XLEN bits
//   RESET_PC  32'h0000_3000 PC value loaded while reset is asserted
//   EXC_VEC   32'h0000_4180 exception entry vector
//   ALIGN_CHK 1             1: misaligned targets (low two bits not 00) trap to EXC_VEC; 0: no check
// PORTS
//   clk        in   1     clock; all state updates on the rising edge
//   reset      in   1     asynchronous, active-low reset
//   stall      in   1     hazard unit: hold PC this cycle
//   br_taken   in   1     ID-stage branch resolved taken
//   br_target  in   XLEN  branch target
//   j_valid    in   1     j/jal in ID
//   j_target   in   XLEN  jump target
//   jr_valid   in   1     jr/jalr in ID
//   jr_target  in   XLEN  register target (RD1)
//   eret_valid in   1     eret committed
//   epc        in   XLEN  CP0 EPC
//   exc_valid  in   1     CP0 exception/interrupt taken
//   pc         out  XLEN  current fetch PC (registered)
//   npc        out  XLEN  PC value to be loaded at the next edge (combinational)
//   redirect   out  1     registered; 1 in the cycle after PC loaded a non-sequential value (flush IF/ID)
//   pend_valid out  1     a deferred redirect is held
//   adr_err    out  1     registered 1-cycle pulse: misaligned target trapped
//   bad_addr   out  XLEN  offending target, held until the next adr_err
// BEHAVIOUR
//   Reset (reset=0, asynchronous): pc=RESET_PC, pend_valid=0, redirect=0, adr_err=0, bad_addr=0, state IDLE.
//   Priority, highest first: exc > eret > jr > j > br > seq (pc+4, modulo 2^XLEN; all-ones-minus-3 wraps to 0).
//   A winning request other than seq is a redirect; its priority code is defined in pc_pkg.
//   FSM states:
//     IDLE, stall=0: pc <= winner target; redirect <= (winner != seq).
//     IDLE, stall=1, request present: capture target and priority; go to PEND; pc held.
//     IDLE, stall=1, no request: pc held.
//     PEND, stall=1: a new request of equal or higher priority overwrites the held entry.
//       Lower-priority requests are dropped.
//     PEND, stall=0: pc <= max(held entry, same-cycle request) by priority; redirect <= 1; go to IDLE.
//   exc_valid ignores stall: pc <= EXC_VEC at the next edge in either state.
//     It clears the pending entry, sets redirect=1 and goes to IDLE.
//   Alignment (ALIGN_CHK=1): checked on the target actually loaded into pc.
//     If the target's low two bits are not 00: pc <= EXC_VEC, adr_err=1 for one cycle,
//     bad_addr <= target, redirect=1.
//     EXC_VEC and seq targets are never checked.
//   Latency: request at cycle N with stall=0 -> pc equals target in cycle N+1; redirect=1 in cycle N+1.
//   npc always equals the value pc will take at the next edge (reset excluded).
//   Reset mid-PEND: the held entry is discarded and pc=RESET_PC.
// STRUCTURE
//   pc_pkg:
//     - priority codes PRI_SEQ=0, PRI_BR=1, PRI_J=2, PRI_JR=3, PRI_ERET=4, PRI_EXC=5 (3 bits)
//     - FSM state encodings IDLE/PEND
//     - default vector constants
//   Sub-module pc_redirect_arb: combinational priority arbiter producing {valid, pri, target}.
//   The top level holds the PC register, pending register, FSM, alignment check and output registers.
// TESTING
//   1. Release reset, no requests, 4 cycles -> pc = 3000, 3004, 3008, 300C; redirect=0.
//   2. br_taken=1 with br_target=3100 and j_valid=1 with j_target=3200, same cycle, stall=0
//      -> next cycle pc=3200, redirect=1.
//   3. stall=1, br_taken=1 (target 3400); next cycle stall=1, jr_valid=1 (jr_target=3500); then stall=0
//      -> pend_valid=1 for 2 cycles, then pc=3500, redirect=1.
//   4. stall=1 with a pending branch, then exc_valid=1
//      -> next cycle pc=4180, pend_valid=0, redirect=1 despite stall.
//   5. jr_valid=1 with jr_target=3502, stall=0
//      -> pc=4180, adr_err pulses 1 cycle, bad_addr=3502.
//   6. pc=FFFF_FFFC, no request -> pc=0000_0000.
//      Separately, assert reset while in PEND -> pc=3000 immediately, pend_valid=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the next-PC unit: redirect priority codes,
// FSM state encoding, default vectors and the alignment helper.
package pc_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

  typedef enum logic [2:0] {
    PRI_SEQ  = 3'd0,
    PRI_BR   = 3'd1,
    PRI_J    = 3'd2,
    PRI_JR   = 3'd3,
    PRI_ERET = 3'd4,
    PRI_EXC  = 3'd5
  } pri_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  function automatic logic misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect arbiter: exc > eret > jr > j > br.
// valid_o is low when only sequential fetch applies.
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int               XLEN    = XLEN_DEF,
  parameter logic [XLEN-1:0]  EXC_VEC = XLEN'(EXC_VEC_DEF)
) (
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            j_valid_i,
  input  logic [XLEN-1:0] j_target_i,
  input  logic            jr_valid_i,
  input  logic [XLEN-1:0] jr_target_i,
  input  logic            eret_valid_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            exc_valid_i,
  output logic            valid_o,
  output pri_e            pri_o,
  output logic [XLEN-1:0] target_o
);

  always_comb begin
    valid_o  = 1'b1;
    pri_o    = PRI_SEQ;
    target_o = '0;
    if (exc_valid_i) begin
      pri_o    = PRI_EXC;
      target_o = EXC_VEC;
    end else if (eret_valid_i) begin
      pri_o    = PRI_ERET;
      target_o = epc_i;
    end else if (jr_valid_i) begin
      pri_o    = PRI_JR;
      target_o = jr_target_i;
    end else if (j_valid_i) begin
      pri_o    = PRI_J;
      target_o = j_target_i;
    end else if (br_taken_i) begin
      pri_o    = PRI_BR;
      target_o = br_target_i;
    end else begin
      valid_o  = 1'b0;
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// PC register and next-PC selection with stall-deferred redirects,
// exception override and target alignment trapping.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(EXC_VEC_DEF),
  parameter bit              ALIGN_CHK = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            j_valid,
  input  logic [XLEN-1:0] j_target,
  input  logic            jr_valid,
  input  logic [XLEN-1:0] jr_target,
  input  logic            eret_valid,
  input  logic [XLEN-1:0] epc,
  input  logic            exc_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] npc,
  output logic            redirect,
  output logic            pend_valid,
  output logic            adr_err,
  output logic [XLEN-1:0] bad_addr
);

  logic            arb_valid;
  pri_e            arb_pri;
  logic [XLEN-1:0] arb_tgt;

  state_e          state_q, state_d;
  pri_e            pend_pri_q, pend_pri_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;
  logic            redirect_q, redirect_d;
  logic            adr_err_q, adr_err_d;

  logic            exc_now;
  logic            take_new;
  logic            load_redir;
  logic            tgt_bad;
  logic [XLEN-1:0] redir_tgt;

  pc_redirect_arb #(
    .XLEN    (XLEN),
    .EXC_VEC (EXC_VEC)
  ) u_arb (
    .br_taken_i   (br_taken),
    .br_target_i  (br_target),
    .j_valid_i    (j_valid),
    .j_target_i   (j_target),
    .jr_valid_i   (jr_valid),
    .jr_target_i  (jr_target),
    .eret_valid_i (eret_valid),
    .epc_i        (epc),
    .exc_valid_i  (exc_valid),
    .valid_o      (arb_valid),
    .pri_o        (arb_pri),
    .target_o     (arb_tgt)
  );

  // A same-cycle request wins over a held entry when its priority is equal or higher.
  always_comb begin
    exc_now    = arb_valid && (arb_pri == PRI_EXC);
    take_new   = arb_valid && ((state_q == ST_IDLE) || (arb_pri >= pend_pri_q));
    load_redir = !stall && (take_new || (state_q == ST_PEND));
    redir_tgt  = take_new ? arb_tgt : pend_tgt_q;
    tgt_bad    = ALIGN_CHK && misaligned(redir_tgt[1:0]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pend_pri_q <= PRI_SEQ;
      pend_tgt_q <= '0;
      pc_q       <= RESET_PC;
      redirect_q <= 1'b0;
      adr_err_q  <= 1'b0;
      bad_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_pri_q <= pend_pri_d;
      pend_tgt_q <= pend_tgt_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      adr_err_q  <= adr_err_d;
      bad_addr_q <= bad_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_pri_d = pend_pri_q;
    pend_tgt_d = pend_tgt_q;
    if (exc_now || !stall) begin
      state_d    = ST_IDLE;
      pend_pri_d = PRI_SEQ;
      pend_tgt_d = '0;
    end else if (take_new) begin
      state_d    = ST_PEND;
      pend_pri_d = arb_pri;
      pend_tgt_d = arb_tgt;
    end else begin
      state_d    = state_q;
    end
  end

  // Exception entry is never alignment-checked and ignores stall.
  always_comb begin
    pc_d       = pc_q;
    redirect_d = 1'b0;
    adr_err_d  = 1'b0;
    bad_addr_d = bad_addr_q;
    if (exc_now) begin
      pc_d       = EXC_VEC;
      redirect_d = 1'b1;
    end else if (load_redir) begin
      redirect_d = 1'b1;
      if (tgt_bad) begin
        pc_d       = EXC_VEC;
        adr_err_d  = 1'b1;
        bad_addr_d = redir_tgt;
      end else begin
        pc_d       = redir_tgt;
      end
    end else if (!stall) begin
      pc_d = pc_q + XLEN'(4);
    end else begin
      pc_d = pc_q;
    end
  end

  assign pc         = pc_q;
  assign npc        = pc_d;
  assign redirect   = redirect_q;
  assign pend_valid = (state_q == ST_PEND);
  assign adr_err    = adr_err_q;
  assign bad_addr   = bad_addr_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: a request-list reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pc_next_unit;

  localparam logic [31:0] RST = 32'h0000_3000;
  localparam logic [31:0] EXC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_taken, j_valid, jr_valid, eret_valid, exc_valid;
  logic [31:0] br_target, j_target, jr_target, epc;
  logic [31:0] pc, npc, bad_addr;
  logic        redirect, pend_valid, adr_err;

  int errors = 0;
  int checks = 0;
  bit run_chk = 1'b0;

  // reference model state
  logic [31:0] m_pc, m_bad, m_pt;
  bit          m_red, m_adr, m_pv;
  int          m_pp;

  pc_next_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .j_valid(j_valid), .j_target(j_target),
    .jr_valid(jr_valid), .jr_target(jr_target),
    .eret_valid(eret_valid), .epc(epc), .exc_valid(exc_valid),
    .pc(pc), .npc(npc), .redirect(redirect), .pend_valid(pend_valid),
    .adr_err(adr_err), .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Request slots indexed by rank: 5 exc, 4 eret, 3 jr, 2 j, 1 br, 0 none.
  task automatic model_next(output logic [31:0] n_pc, output bit n_red, output bit n_adr,
                            output logic [31:0] n_bad, output bit n_pv, output int n_pp,
                            output logic [31:0] n_pt);
    bit          rv [6];
    logic [31:0] rt [6];
    int          w;
    logic [31:0] tgt;
    rv = '{1'b0, br_taken, j_valid, jr_valid, eret_valid, exc_valid};
    rt = '{32'h0, br_target, j_target, jr_target, epc, EXC};
    w = 0;
    for (int k = 1; k < 6; k++) if (rv[k]) w = k;
    n_pc = m_pc; n_red = 1'b0; n_adr = 1'b0; n_bad = m_bad;
    n_pv = m_pv; n_pp = m_pp; n_pt = m_pt;
    if (w == 5) begin
      n_pc = EXC; n_red = 1'b1; n_pv = 1'b0;
    end else if (stall) begin
      if (w > 0 && (!m_pv || w >= m_pp)) begin
        n_pv = 1'b1; n_pp = w; n_pt = rt[w];
      end
    end else begin
      n_pv = 1'b0;
      tgt  = m_pc + 32'd4;
      if (m_pv && m_pp > w) begin
        tgt = m_pt; n_red = 1'b1;
      end else if (w > 0) begin
        tgt = rt[w]; n_red = 1'b1;
      end
      if (n_red && (tgt % 4) != 0) begin
        n_bad = tgt; n_adr = 1'b1; tgt = EXC;
      end
      n_pc = tgt;
    end
  endtask

  // model register update
  always @(posedge clk or negedge reset) begin
    logic [31:0] a_pc, a_bad, a_pt;
    bit a_red, a_adr, a_pv;
    int a_pp;
    if (!reset) begin
      m_pc = RST; m_bad = 32'h0; m_pt = 32'h0; m_red = 1'b0; m_adr = 1'b0; m_pv = 1'b0; m_pp = 0;
    end else begin
      model_next(a_pc, a_red, a_adr, a_bad, a_pv, a_pp, a_pt);
      m_pc = a_pc; m_red = a_red; m_adr = a_adr; m_bad = a_bad; m_pv = a_pv; m_pp = a_pp; m_pt = a_pt;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    logic [31:0] e_pc, e_bad, e_pt;
    bit e_red, e_adr, e_pv;
    int e_pp;
    if (run_chk) begin
      chk("pc", pc, m_pc);
      chk("redirect", {31'b0, redirect}, {31'b0, m_red});
      chk("pend_valid", {31'b0, pend_valid}, {31'b0, m_pv});
      chk("adr_err", {31'b0, adr_err}, {31'b0, m_adr});
      chk("bad_addr", bad_addr, m_bad);
      if (reset) begin
        model_next(e_pc, e_red, e_adr, e_bad, e_pv, e_pp, e_pt);
        chk("npc", npc, e_pc);
      end
    end
  end

  task automatic clr();
    stall = 1'b0; br_taken = 1'b0; j_valid = 1'b0; jr_valid = 1'b0;
    eret_valid = 1'b0; exc_valid = 1'b0;
    br_target = 32'h0; j_target = 32'h0; jr_target = 32'h0; epc = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    #2 reset = 1'b0;
    run_chk = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_pc", pc, RST);
    chk("rst_pend", {31'b0, pend_valid}, 32'h0);
    tick();
    reset = 1'b1;

    // sequential fetch
    chk("seq0", pc, 32'h3000);
    tick(); chk("seq1", pc, 32'h3004);
    tick(); chk("seq2", pc, 32'h3008);
    tick(); chk("seq3", pc, 32'h300C);
    chk("seq_red", {31'b0, redirect}, 32'h0);

    // j beats br in the same cycle
    br_taken = 1'b1; br_target = 32'h3100; j_valid = 1'b1; j_target = 32'h3200;
    tick(); clr();
    chk("j_pc", pc, 32'h3200);
    chk("j_red", {31'b0, redirect}, 32'h1);

    // stalled br replaced by stalled jr, applied on release
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h3400;
    tick(); clr(); stall = 1'b1;
    chk("p1_pend", {31'b0, pend_valid}, 32'h1);
    chk("p1_hold", pc, 32'h3200);
    jr_valid = 1'b1; jr_target = 32'h3500;
    tick(); clr();
    chk("p2_pend", {31'b0, pend_valid}, 32'h1);
    tick();
    chk("p3_pc", pc, 32'h3500);
    chk("p3_red", {31'b0, redirect}, 32'h1);
    chk("p3_pend", {31'b0, pend_valid}, 32'h0);

    // lower-priority request during PEND is dropped
    stall = 1'b1; jr_valid = 1'b1; jr_target = 32'h3900;
    tick(); clr(); stall = 1'b1; br_taken = 1'b1; br_target = 32'h3A00;
    tick(); clr();
    tick();
    chk("drop_pc", pc, 32'h3900);

    // exception overrides a pending branch under stall
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h3600;
    tick(); clr(); stall = 1'b1; exc_valid = 1'b1;
    tick(); clr();
    chk("exc_pc", pc, EXC);
    chk("exc_pend", {31'b0, pend_valid}, 32'h0);
    chk("exc_red", {31'b0, redirect}, 32'h1);
    tick();
    chk("exc_seq", pc, 32'h4184);

    // eret beats jr and br
    eret_valid = 1'b1; epc = 32'h3700; jr_valid = 1'b1; jr_target = 32'h3800;
    br_taken = 1'b1; br_target = 32'h3B00;
    tick(); clr();
    chk("eret_pc", pc, 32'h3700);

    // misaligned jr target traps
    jr_valid = 1'b1; jr_target = 32'h3502;
    tick(); clr();
    chk("mis_pc", pc, EXC);
    chk("mis_adr", {31'b0, adr_err}, 32'h1);
    chk("mis_bad", bad_addr, 32'h3502);
    tick();
    chk("mis_adr_off", {31'b0, adr_err}, 32'h0);
    chk("mis_bad_hold", bad_addr, 32'h3502);

    // misaligned pending target traps on release
    stall = 1'b1; j_valid = 1'b1; j_target = 32'h3C01;
    tick(); clr();
    tick();
    chk("pmis_pc", pc, EXC);
    chk("pmis_bad", bad_addr, 32'h3C01);

    // stall with no request holds pc
    tick(); stall = 1'b1;
    tick(); tick(); clr();
    chk("hold_pc", pc, 32'h4184);

    // wrap at the top of the address space
    jr_valid = 1'b1; jr_target = 32'hFFFF_FFFC;
    tick(); clr();
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", pc, 32'h0000_0000);

    // reset while a redirect is pending
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h3400;
    tick(); clr();
    chk("rp_pend", {31'b0, pend_valid}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rp_pc", pc, RST);
    chk("rp_pend0", {31'b0, pend_valid}, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("rp_seq", pc, 32'h3004);

    @(negedge clk);
    run_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
